// File: rtl/dvp_tx_pkg.sv
// dvp_tx_pkg: frame FSM state type and frame-geometry helpers shared by the DVP transmitter.
package dvp_tx_pkg;
  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_e;
  localparam int DEF_LINE_SLOTS  = 2 * 640 + 288;
  localparam int DEF_FRAME_LINES = 4 + 16 + 480 + 8;
  function automatic int line_slots(int h_active, int h_blank);
    return 2 * h_active + h_blank;
  endfunction
  function automatic int frame_lines(int v_sync, int v_back, int v_active, int v_front);
    return v_sync + v_back + v_active + v_front;
  endfunction
endpackage

// File: rtl/dvp_timing_gen.sv
// dvp_timing_gen: pclk phase, h/v slot counters and the frame FSM.
// Produces vsync, href, byte parity and the FIFO fetch/capture strobes.
module dvp_timing_gen
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 288,
  parameter int V_SYNC   = 4,
  parameter int V_BACK   = 16,
  parameter int V_FRONT  = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tx_en_i,
  output logic pclk_o,
  output logic vsync_o,
  output logic href_o,
  output logic odd_o,
  output logic fetch_o,
  output logic cap_o,
  output logic frame_done_o
);
  localparam int LINE = line_slots(H_ACTIVE, H_BLANK);
  localparam int VM1  = V_SYNC > V_BACK ? V_SYNC : V_BACK;
  localparam int VM2  = V_ACTIVE > V_FRONT ? V_ACTIVE : V_FRONT;
  localparam int VMAX = VM1 > VM2 ? VM1 : VM2;
  localparam int HW   = $clog2(LINE);
  localparam int VW   = VMAX > 1 ? $clog2(VMAX) : 1;

  state_e        state_q, state_d;
  logic          phase_q;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          done_q, done_d, eol, eos, hi_next;
  int            lines;

  // *_d describe the slot that starts at the next pclk falling edge
  always_comb begin
    lines   = state_q == VSYNC ? V_SYNC : state_q == VBACK ? V_BACK :
              state_q == ACTIVE ? V_ACTIVE : V_FRONT;
    eol     = int'(h_q) == LINE - 1;
    eos     = int'(v_q) == lines - 1;
    state_d = state_q;
    h_d     = h_q + 1'b1;
    v_d     = v_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      state_d = tx_en_i ? VSYNC : IDLE;
      h_d     = '0;
    end else if (eol) begin
      h_d = '0;
      v_d = eos ? '0 : v_q + 1'b1;
      if (eos) begin
        state_d = state_q == VSYNC ? VBACK : state_q == VBACK ? ACTIVE :
                  state_q == ACTIVE ? VFRONT : tx_en_i ? VSYNC : IDLE;
        done_d  = state_q == VFRONT;
      end
    end
    hi_next = state_d == ACTIVE && int'(h_d) < 2 * H_ACTIVE && !h_d[0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= !phase_q;
      done_q  <= phase_q && done_d;
      if (phase_q) begin
        state_q <= state_d;
        h_q     <= h_d;
        v_q     <= v_d;
      end
    end
  end

  assign pclk_o       = phase_q;
  assign vsync_o      = state_q == VSYNC;
  assign href_o       = state_q == ACTIVE && int'(h_q) < 2 * H_ACTIVE;
  assign odd_o        = h_q[0];
  assign fetch_o      = !phase_q && hi_next;
  assign cap_o        = phase_q && hi_next;
  assign frame_done_o = done_q;
endmodule

// File: rtl/dvp_tx.sv
// dvp_tx: DVP source; pulls RGB565 pixels from a FIFO and serialises them high byte first
// onto an 8-bit bus timed by dvp_timing_gen.
module dvp_tx
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 288,
  parameter int V_SYNC   = 4,
  parameter int V_BACK   = 16,
  parameter int V_FRONT  = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        tx_en,
  input  logic        pix_empty,
  input  logic [15:0] pix_data,
  output logic        pix_req,
  output logic        dvp_pclk,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        frame_done,
  output logic        underflow
);
  logic        odd, fetch, cap, req_q, uf_q;
  logic [15:0] hold_q, hold_d;

  dvp_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
  ) u_timing (
    .clk_i(sys_clk), .rst_ni(sys_rst_n), .tx_en_i(tx_en),
    .pclk_o(dvp_pclk), .vsync_o(dvp_vsync), .href_o(dvp_href), .odd_o(odd),
    .fetch_o(fetch), .cap_o(cap), .frame_done_o(frame_done)
  );

  assign pix_req = fetch && !pix_empty;
  // a skipped request leaves a black pixel so line timing never stalls
  assign hold_d  = cap ? (req_q ? pix_data : 16'h0000) : hold_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_q  <= 1'b0;
      hold_q <= 16'h0000;
      uf_q   <= 1'b0;
    end else begin
      req_q  <= pix_req;
      hold_q <= hold_d;
      uf_q   <= uf_q | (fetch & pix_empty);
    end
  end

  assign underflow = uf_q;
  assign dvp_data  = !dvp_href ? 8'h00 : odd ? hold_q[7:0] : hold_q[15:8];
endmodule

// File: tb/tb_dvp_tx.sv
// tb_dvp_tx: randomized bench for dvp_tx on a small frame, checked every sys_clk against
// a slot-arithmetic model of the DVP frame plus hand-computed frame-level expectations.
module tb_dvp_tx;
  localparam int HA = 4, VA = 2, HB = 4, VS = 1, VB = 1, VF = 1;
  localparam int LINE = 2 * HA + HB;
  localparam int NSLOT = LINE * (VS + VB + VA + VF);

  logic        sys_clk = 0, sys_rst_n = 0, tx_en = 0, pix_empty = 0;
  logic [15:0] pix_data = 0;
  logic        pix_req, dvp_pclk, dvp_vsync, dvp_href, frame_done, underflow;
  logic [7:0]  dvp_data;

  dvp_tx #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_en(tx_en), .pix_empty(pix_empty),
    .pix_data(pix_data), .pix_req(pix_req), .dvp_pclk(dvp_pclk), .dvp_vsync(dvp_vsync),
    .dvp_href(dvp_href), .dvp_data(dvp_data), .frame_done(frame_done), .underflow(underflow)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0, n_bad = 0;
  logic [15:0] fifo [0:1023];
  int rd = 0;
  int k = -1, f0 = 0, s = 0;
  bit busy = 0, uf = 0, tx_prev = 0, req_seen = 0, force_on = 0, rand_on = 0;
  int force_idx = -1;
  logic [15:0] cur_pix = 0, next_pix = 0;
  bit e_done, e_vs, e_href, e_req, e_pclk, hi1;
  logic [7:0] e_data;
  int done_cnt = 0, viol = 0, req_cnt = 0, vs_slots = 0, vs_k = 0, frame_len = 0;
  logic [7:0] bytes[$];
  logic [9:0] prev_bus = 0;
  bit prev_ok = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_act(int sl);
    int l = sl / LINE, h = sl % LINE;
    return l >= VS + VB && l < VS + VB + VA && h < 2 * HA;
  endfunction

  // model: slot index since frame start gives line/column; everything follows from that
  always @(negedge sys_clk) begin
    e_done = 0;
    if (!sys_rst_n) begin
      k = -1; busy = 0; uf = 0; cur_pix = 0;
    end else begin
      k++;
      if (k >= 2 && k % 2 == 0) begin
        if (!busy) begin
          if (tx_prev) begin busy = 1; f0 = k; end
        end else if (k - f0 == 2 * NSLOT) begin
          e_done = 1;
          if (tx_prev) f0 = k; else busy = 0;
        end
      end
    end
    s = busy ? (k - f0) / 2 : 0;
    if (busy && k % 2 == 0 && is_act(s) && (s % LINE) % 2 == 0) cur_pix = next_pix;
    e_pclk = sys_rst_n && k[0];
    e_vs   = busy && s / LINE < VS;
    e_href = busy && is_act(s);
    e_data = !e_href ? 8'h00 : ((s % LINE) % 2 == 1) ? cur_pix[7:0] : cur_pix[15:8];
    hi1    = busy && k % 2 == 0 && is_act(s + 1) && ((s + 1) % LINE) % 2 == 0;
    e_req  = hi1 && !pix_empty;
    chk("pclk", dvp_pclk, e_pclk);
    chk("vsync", dvp_vsync, e_vs);
    chk("href", dvp_href, e_href);
    chk("data", dvp_data, e_data);
    chk("pix_req", pix_req, e_req);
    chk("frame_done", frame_done, e_done);
    chk("underflow", underflow, uf);
    if (hi1) begin
      next_pix = pix_empty ? 16'h0000 : fifo[rd & 1023];
      if (pix_empty) uf = 1;
    end
    req_seen = pix_req;
    tx_prev  = tx_en;
    req_cnt += int'(pix_req);
    if (frame_done) begin done_cnt++; frame_len = k - vs_k; end
    if (dvp_vsync && !prev_bus[9] && prev_ok) vs_k = k;
    if (dvp_pclk && dvp_vsync) vs_slots++;
    if (dvp_pclk && dvp_href) bytes.push_back(dvp_data);
    if (prev_ok && sys_rst_n && dvp_pclk && {dvp_vsync, dvp_href, dvp_data} != prev_bus) viol++;
    prev_bus = {dvp_vsync, dvp_href, dvp_data};
    prev_ok  = sys_rst_n;
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge sys_clk); #1;
      if (req_seen) begin pix_data = fifo[rd & 1023]; rd++; end
      pix_empty = force_on ? (rd == force_idx && !uf) : rand_on ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  endtask

  task automatic wait_done(string nm, int budget);
    int c0 = done_cnt;
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      cyc(1);
      got = done_cnt != c0;
    end
    if (!got) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_href(int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      cyc(1);
      got = dvp_href;
    end
    if (!got) chk("href_timeout", 0, 1);
  endtask

  task automatic frame_start();
    bytes.delete(); req_cnt = 0; vs_slots = 0;
  endtask

  initial begin
    int n;
    fifo[0] = 16'h1234; fifo[1] = 16'h5678; fifo[2] = 16'h9abc; fifo[3] = 16'hdef0;
    for (int i = 4; i < 1024; i++) fifo[i] = 16'($urandom);
    cyc(3);
    chk("rst_pclk", dvp_pclk, 0);
    chk("rst_data", dvp_data, 0);
    sys_rst_n = 1;
    cyc(4);
    // frame 1 then back-to-back frame 2, dropped mid-ACTIVE
    frame_start();
    tx_en = 1;
    n = 0;
    for (int i = 0; i < 6 && !dvp_vsync; i++) begin cyc(1); n++; end
    chk("start_latency_le2", n <= 2, 1);
    wait_done("frame1", 300);
    chk("f1_byte0", bytes.size() > 0 ? bytes[0] : 8'hxx, 8'h12);
    chk("f1_byte1", bytes.size() > 1 ? bytes[1] : 8'hxx, 8'h34);
    chk("f1_byte2", bytes.size() > 2 ? bytes[2] : 8'hxx, 8'h56);
    chk("f1_byte3", bytes.size() > 3 ? bytes[3] : 8'hxx, 8'h78);
    chk("f1_nbytes", bytes.size(), 2 * HA * VA);
    chk("f1_nreq", req_cnt, 8);
    chk("f1_vs_slots", vs_slots, 12);
    chk("f1_len", frame_len, 120);
    chk("b2b_vsync", dvp_vsync, 1);
    frame_start();
    wait_href(200);
    tx_en = 0;
    wait_done("frame2", 300);
    chk("f2_nbytes", bytes.size(), 16);
    chk("f2_nreq", req_cnt, 8);
    chk("f2_vs_slots", vs_slots, 12);
    chk("f2_len", frame_len, 120);
    cyc(40);
    chk("idle_vsync", dvp_vsync, 0);
    chk("no_underflow_yet", underflow, 0);
    // empty FIFO exactly at the third pixel of line 0
    frame_start();
    force_idx = rd + 2; force_on = 1;
    tx_en = 1; cyc(2); tx_en = 0;
    wait_done("uf_frame", 300);
    force_on = 0;
    chk("uf_set", underflow, 1);
    chk("uf_byte4", bytes.size() > 4 ? bytes[4] : 8'hxx, 8'h00);
    chk("uf_byte5", bytes.size() > 5 ? bytes[5] : 8'hxx, 8'h00);
    chk("uf_nbytes", bytes.size(), 16);
    chk("uf_nreq", req_cnt, 7);
    chk("uf_len", frame_len, 120);
    cyc(10);
    chk("uf_sticky", underflow, 1);
    // random FIFO starvation across two back-to-back frames
    rand_on = 1;
    tx_en = 1;
    wait_done("rand1", 300);
    tx_en = 0;
    wait_done("rand2", 300);
    rand_on = 0;
    cyc(20);
    // asynchronous reset mid-line, then a clean restart
    tx_en = 1; cyc(2); tx_en = 0;
    cyc(61);
    sys_rst_n = 0;
    #1;
    chk("arst_pclk", dvp_pclk, 0);
    chk("arst_vsync", dvp_vsync, 0);
    chk("arst_href", dvp_href, 0);
    chk("arst_data", dvp_data, 0);
    chk("arst_req", pix_req, 0);
    chk("arst_uf", underflow, 0);
    cyc(3);
    sys_rst_n = 1;
    cyc(3);
    frame_start();
    tx_en = 1; cyc(2); tx_en = 0;
    wait_done("restart", 300);
    chk("rs_nbytes", bytes.size(), 16);
    chk("rs_nreq", req_cnt, 8);
    chk("rs_vs_slots", vs_slots, 12);
    chk("rs_len", frame_len, 120);
    cyc(10);
    chk("setup_hold_viol", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
